// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Lets the instruction-fetch port (I) and the load/store port (D) share one
//   single-port memory. Each access runs as request -> memory handshake ->
//   one-cycle valid pulse. D has priority. A starvation counter forces an I
//   grant after STARVE_MAX consecutive D grants that were made while I was
//   waiting.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   ireq/iaddr            : fetch request (held until ivalid) and its address
//   ivalid/irdata/istall  : fetch completion pulse, fetched word, fetch stall
//   dreq/dwe/damp/daddr/dwdata
//                         : load/store request, store flag, byte lanes,
//                           address and store data
//   dvalid/drdata/dstall  : data completion pulse, raw loaded word, data stall
//   mem_req/mem_we/mem_amp/mem_addr/mem_wdata
//                         : registered memory request; held until mem_ack
//   mem_ack/mem_rdata     : one-cycle memory completion and its read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int STARVE_MAX = 4     // must be >= 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ireq,
    input  logic [ADDR_SIZE-1:0] iaddr,
    output logic                 ivalid,
    output logic [XLEN-1:0]      irdata,
    output logic                 istall,

    input  logic                 dreq,
    input  logic                 dwe,
    input  logic [3:0]           damp,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic [XLEN-1:0]      dwdata,
    output logic                 dvalid,
    output logic [XLEN-1:0]      drdata,
    output logic                 dstall,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [3:0]           mem_amp,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_ack,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       starve_q;
    logic                   ivalid_q;
    logic                   dvalid_q;
    logic [XLEN-1:0]        irdata_q;
    logic [XLEN-1:0]        drdata_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [3:0]             mem_amp_q;
    logic [ADDR_SIZE-1:0]   mem_addr_q;
    logic [XLEN-1:0]        mem_wdata_q;

    // D wins unless I has already waited through STARVE_MAX D grants.
    logic grant_d_d;
    logic grant_i_d;

    always_comb begin
        grant_d_d = dreq && !(ireq && (starve_q == STARVE_LIM));
        grant_i_d = ireq && !grant_d_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_amp_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Valid pulses last exactly one cycle.
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_d_d) begin
                        state_q     <= DBUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dwe;
                        mem_amp_q   <= damp;
                        mem_addr_q  <= daddr;
                        mem_wdata_q <= dwdata;
                        // A D grant while I waits can only happen below the
                        // limit, so the increment never overflows.
                        if (ireq) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end else if (grant_i_d) begin
                        state_q     <= IBUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_amp_q   <= 4'b1111;
                        mem_addr_q  <= iaddr;
                        mem_wdata_q <= '0;
                        starve_q    <= '0;
                    end
                end

                IBUSY: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        irdata_q  <= mem_rdata;
                        ivalid_q  <= 1'b1;
                    end
                end

                DBUSY: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            drdata_q <= mem_rdata;
                        end
                        dvalid_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ivalid    = ivalid_q;
        dvalid    = dvalid_q;
        irdata    = irdata_q;
        drdata    = drdata_q;
        istall    = ireq & ~ivalid_q;
        dstall    = dreq & ~dvalid_q;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_amp   = mem_amp_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a table of single accesses with
//   hand-computed expectations, then hand-written sequences for priority,
//   starvation and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] irdata;
    logic        istall;
    logic        dreq;
    logic        dwe;
    logic [3:0]  damp;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        dvalid;
    logic [31:0] drdata;
    logic        dstall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_amp;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .XLEN      (32),
        .ADDR_SIZE (32),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ireq     (ireq),
        .iaddr    (iaddr),
        .ivalid   (ivalid),
        .irdata   (irdata),
        .istall   (istall),
        .dreq     (dreq),
        .dwe      (dwe),
        .damp     (damp),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dvalid   (dvalid),
        .drdata   (drdata),
        .dstall   (dstall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_amp  (mem_amp),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          is_i;       // 1 = fetch, 0 = load/store
        logic        we;
        logic [3:0]  amp;
        logic [31:0] addr;
        logic [31:0] wdata;      // driven on dwdata (also during fetches)
        logic [31:0] rdata;      // memory answer
        int          delay;      // cycles from mem_req high to mem_ack
        logic        exp_we;
        logic [3:0]  exp_amp;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;  // granted port rdata after valid
        logic [31:0] exp_other;  // other port rdata (must be unchanged)
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_req_seen"}, {31'b0, ok}, 32'd1);
    endtask

    // Starts and ends just after a falling edge.
    task automatic run_vec(input int n, input vec_t v);
        string tag;
        logic [31:0] addr0;
        tag = $sformatf("vec%0d", n);
        iaddr  = v.addr;
        daddr  = v.addr;
        dwe    = v.we;
        damp   = v.amp;
        dwdata = v.wdata;
        if (v.is_i) ireq = 1'b1; else dreq = 1'b1;
        wait_req(tag);
        check({tag, "_we"},    {31'b0, mem_we},  {31'b0, v.exp_we});
        check({tag, "_amp"},   {28'b0, mem_amp}, {28'b0, v.exp_amp});
        check({tag, "_addr"},  mem_addr, v.addr);
        check({tag, "_wdata"}, mem_wdata, v.exp_wdata);
        check({tag, "_stall"}, {31'b0, (v.is_i ? istall : dstall)}, 32'd1);
        addr0 = mem_addr;
        for (int k = 1; k < v.delay; k++) begin
            @(negedge clk);
            check({tag, "_hold_req"},   {31'b0, mem_req}, 32'd1);
            check({tag, "_hold_addr"},  mem_addr, addr0);
            check({tag, "_hold_stall"}, {31'b0, (v.is_i ? istall : dstall)}, 32'd1);
            check({tag, "_hold_novalid"}, {30'b0, ivalid, dvalid}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5555_AAAA;
        check({tag, "_valid"},   {30'b0, ivalid, dvalid}, v.is_i ? 32'd2 : 32'd1);
        check({tag, "_unstall"}, {30'b0, istall, dstall}, 32'd0);
        check({tag, "_req_drop"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_rdata"},   v.is_i ? irdata : drdata, v.exp_rdata);
        check({tag, "_other"},   v.is_i ? drdata : irdata, v.exp_other);
        ireq = 1'b0;
        dreq = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'b0, ivalid, dvalid}, 32'd0);
    endtask

    // Serves one grant with a one-cycle ack; reports which port was granted.
    task automatic serve(input string name, output bit was_i);
        wait_req(name);
        was_i     = (mem_addr == 32'h0000_0100);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack   = 1'b0;
        check({name, "_valid"}, {30'b0, ivalid, dvalid}, was_i ? 32'd2 : 32'd1);
    endtask

    initial begin
        bit was_i;

        //              is_i we   amp      addr          wdata         rdata         dly ewe eamp     ewdata        erdata        eother
        vecs[0] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0050_0093, 1, 1'b0, 4'b1111, 32'h0000_0000, 32'h0050_0093, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b0, 4'b1111, 32'h0000_3000, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0050_0093};
        vecs[2] = '{1'b0, 1'b1, 4'b1100, 32'h0000_2004, 32'hABCD_0000, 32'h1234_5678, 2, 1'b1, 4'b1100, 32'hABCD_0000, 32'hDEAD_BEEF, 32'h0050_0093};
        vecs[3] = '{1'b0, 1'b1, 4'b0010, 32'h0000_2005, 32'h0000_5A00, 32'h8765_4321, 5, 1'b1, 4'b0010, 32'h0000_5A00, 32'hDEAD_BEEF, 32'h0050_0093};
        vecs[4] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0104, 32'h1357_9BDF, 32'hFFF0_0113, 3, 1'b0, 4'b1111, 32'h0000_0000, 32'hFFF0_0113, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 4'b0011, 32'h0000_3002, 32'h0000_0000, 32'h0000_CAFE, 1, 1'b0, 4'b0011, 32'h0000_0000, 32'h0000_CAFE, 32'hFFF0_0113};

        reset = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
        damp = '0; daddr = '0; dwdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valids", {30'b0, ivalid, dvalid}, 32'd0);
        check("rst_stalls", {30'b0, istall, dstall}, 32'd0);
        check("rst_mem_ctl", {26'b0, mem_req, mem_we, mem_amp}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_irdata", irdata, 32'd0);
        check("rst_drdata", drdata, 32'd0);

        for (int n = 0; n < 6; n++) begin
            run_vec(n, vecs[n]);
        end

        // Simultaneous requests: store goes first, fetch right after.
        iaddr = 32'h0000_0200; ireq = 1'b1;
        daddr = 32'h0000_2004; dwe = 1'b1; damp = 4'b1100; dwdata = 32'hABCD_0000; dreq = 1'b1;
        wait_req("prio_d");
        check("prio_d_we",   {31'b0, mem_we}, 32'd1);
        check("prio_d_amp",  {28'b0, mem_amp}, 32'hC);
        check("prio_d_addr", mem_addr, 32'h0000_2004);
        check("prio_istall", {30'b0, istall, dstall}, 32'd3);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("prio_d_valid", {30'b0, ivalid, dvalid}, 32'd1);
        dreq = 1'b0;
        wait_req("prio_i");
        check("prio_i_addr", mem_addr, 32'h0000_0200);
        check("prio_i_ctl",  {27'b0, mem_we, mem_amp}, 32'h0000_000F);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_ack = 1'b0;
        check("prio_i_valid", {30'b0, ivalid, dvalid}, 32'd2);
        check("prio_i_rdata", irdata, 32'h0000_0013);
        ireq = 1'b0;
        @(negedge clk);

        // Starvation: ireq held, dreq held -> D,D,D,D,I repeating.
        iaddr = 32'h0000_0100; ireq = 1'b1;
        daddr = 32'h0000_4000; dwe = 1'b0; damp = 4'b1111; dreq = 1'b1;
        for (int g = 0; g < 10; g++) begin
            serve($sformatf("starve%0d", g), was_i);
            check($sformatf("starve%0d_port", g), {31'b0, was_i}, (g % 5 == 4) ? 32'd1 : 32'd0);
        end
        ireq = 1'b0;
        dreq = 1'b0;
        @(negedge clk);
        check("starve_idle", {31'b0, mem_req}, 32'd0);

        // Reset in the middle of a data access.
        daddr = 32'h0000_5000; dwe = 1'b1; damp = 4'b1111; dwdata = 32'hCAFE_BABE; dreq = 1'b1;
        wait_req("rstmid");
        reset = 1'b1;
        #1;
        check("rstmid_ctl",   {26'b0, mem_req, mem_we, mem_amp}, 32'd0);
        check("rstmid_addr",  mem_addr, 32'd0);
        check("rstmid_wdata", mem_wdata, 32'd0);
        check("rstmid_rdata", irdata | drdata, 32'd0);
        check("rstmid_valid", {30'b0, ivalid, dvalid}, 32'd0);
        dreq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid_late_ack_valid", {30'b0, ivalid, dvalid}, 32'd0);
        check("rstmid_late_ack_req",   {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("rstmid_quiet", {29'b0, mem_req, ivalid, dvalid}, 32'd0);
        check("rstmid_drdata", drdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
